// File: rtl/decim_pkg.sv
// Shared defaults and helpers for the I/Q power-of-two decimator.
package decim_pkg;

  localparam int DEF_DW           = 16;
  localparam int DEF_MAX_DEC_LOG2 = 4;
  localparam int DEF_ACCW         = DEF_DW + DEF_MAX_DEC_LOG2;

  // Requested log2 factor limited to what the accumulator can hold.
  function automatic int unsigned clamp_k(input int unsigned k_in,
                                          input int unsigned max_k = DEF_MAX_DEC_LOG2);
    return (k_in > max_k) ? max_k : k_in;
  endfunction

endpackage

// File: rtl/decim_lane.sv
// One decimator lane: boxcar accumulator, pick/average select, rounding
// shift and output register. Frame position comes from the top level.
module decim_lane #(
  parameter int DW    = 16,
  parameter int ACCW  = 20,
  parameter int LOG2W = 3
) (
  input  logic                    clk_120m,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic                    i_sync,
  input  logic [LOG2W-1:0]        i_k,
  input  logic                    i_avg,
  input  logic signed [DW-1:0]    i_din,
  output logic signed [DW-1:0]    o_dout
);

  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] w_ext;
  logic signed [ACCW-1:0] w_sum;
  logic signed [ACCW-1:0] w_rnd;
  logic signed [ACCW-1:0] w_res;

  always_comb begin
    w_ext = ACCW'(i_din);
    w_sum = i_first ? w_ext : (r_acc + w_ext);
    // Half-LSB bias before the shift; zero for k=0 so the sample passes through.
    w_rnd = (i_k == '0) ? '0 : (ACCW'(1) <<< (i_k - LOG2W'(1)));
    w_res = (w_sum + w_rnd) >>> i_k;
  end

  always_ff @(posedge clk_120m or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      o_dout <= '0;
    end else begin
      if (i_valid) begin
        r_acc <= w_sum;
      end else if (i_sync) begin
        r_acc <= '0;
      end
      if (i_last) begin
        o_dout <= i_avg ? w_res[DW-1:0] : i_din;
      end
    end
  end

endmodule

// File: rtl/decim_iq_cfg.sv
// Runtime power-of-two I/Q decimator (pick or rounded boxcar average) with
// frame sync, valid gaps and a one-cycle output strobe.
module decim_iq_cfg
  import decim_pkg::*;
#(
  parameter int DW           = DEF_DW,
  parameter int MAX_DEC_LOG2 = DEF_MAX_DEC_LOG2,
  parameter int LOG2W        = 3
) (
  input  logic                  clk_120m,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic signed [DW-1:0]  data_ddc_I,
  input  logic signed [DW-1:0]  data_ddc_Q,
  input  logic [LOG2W-1:0]      dec_log2,
  input  logic                  avg_en,
  input  logic                  sync,
  output logic                  out_valid,
  output logic signed [DW-1:0]  data_I,
  output logic signed [DW-1:0]  data_Q
);

  localparam int ACCW = DW + MAX_DEC_LOG2;
  localparam int CNTW = MAX_DEC_LOG2;

  logic [CNTW-1:0]  r_cnt;
  logic [LOG2W-1:0] r_k;
  logic             r_avg;
  logic             r_out_valid;

  logic [LOG2W-1:0] w_k_cfg;
  logic [LOG2W-1:0] w_k;
  logic             w_avg;
  logic             w_load;
  logic [CNTW-1:0]  w_cnt;
  logic [CNTW-1:0]  w_last_idx;
  logic             w_first;
  logic             w_last;

  // Config is taken at frame start, so the starting sample already uses it.
  always_comb begin
    w_k_cfg    = LOG2W'(clamp_k(32'(dec_log2), MAX_DEC_LOG2));
    w_load     = sync | (in_valid & (r_cnt == '0));
    w_k        = w_load ? w_k_cfg : r_k;
    w_avg      = w_load ? avg_en : r_avg;
    w_cnt      = sync ? '0 : r_cnt;
    w_last_idx = CNTW'((32'd1 << w_k) - 32'd1);
    w_first    = in_valid & (w_cnt == '0);
    w_last     = in_valid & (w_cnt == w_last_idx);
  end

  always_ff @(posedge clk_120m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_k         <= '0;
      r_avg       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_last;
      if (w_load) begin
        r_k   <= w_k_cfg;
        r_avg <= avg_en;
      end
      if (in_valid) begin
        r_cnt <= w_last ? '0 : (w_cnt + CNTW'(1));
      end else if (sync) begin
        r_cnt <= '0;
      end
    end
  end

  decim_lane #(.DW(DW), .ACCW(ACCW), .LOG2W(LOG2W)) u_lane_i (
    .clk_120m (clk_120m),
    .rst_n    (rst_n),
    .i_valid  (in_valid),
    .i_first  (w_first),
    .i_last   (w_last),
    .i_sync   (sync),
    .i_k      (w_k),
    .i_avg    (w_avg),
    .i_din    (data_ddc_I),
    .o_dout   (data_I)
  );

  decim_lane #(.DW(DW), .ACCW(ACCW), .LOG2W(LOG2W)) u_lane_q (
    .clk_120m (clk_120m),
    .rst_n    (rst_n),
    .i_valid  (in_valid),
    .i_first  (w_first),
    .i_last   (w_last),
    .i_sync   (sync),
    .i_k      (w_k),
    .i_avg    (w_avg),
    .i_din    (data_ddc_Q),
    .o_dout   (data_Q)
  );

  assign out_valid = r_out_valid;

endmodule
